regfile_spill: RTL
==================

// Module: regfile_spill
// PURPOSE
//  Context save/restore engine for the 8-bit processor register file.
//  Save: reads all 6 physical register entries through one RF read port and
//   writes them to data memory at BaseAddr..BaseAddr+5.
//  Restore: reads those 6 memory words back and writes them through the RF write port.
//  Sits between the control unit (Start/Done) and the RF/data-memory ports; muxed in while Busy.
// PARAMETERS
//  W   8  data path width (RF entry and memory word)
//  A   2  RF address pointer width
//  MA  8  data memory address width
// PORTS
//  Clk        in   1   clock, all state updates on posedge
//  ResetN     in   1   synchronous, active-low reset
//  Start      in   1   begin operation; sampled only in IDLE
//  Mode       in   1   0 = save (RF->mem), 1 = restore (mem->RF); latched with Start
//  BaseAddr   in   MA  first memory address; latched with Start
//  Busy       out  1   high in SAVE/RD_REQ/RD_WR states
//  Done       out  1   one-cycle completion pulse
//  RfRaddr    out  A   RF read address (save)
//  RfWaddr    out  A   RF write address (restore)
//  RfUppOrLow out  1   RF half select for slots using a half
//  RfWriteEn  out  1   RF write strobe
//  RfDataIn   out  W   RF write data
//  RfRdData   in   W   RF read data, combinational from RfRaddr/RfUppOrLow
//  MemAddr    out  MA  memory address
//  MemWrEn    out  1   memory write request
//  MemRdEn    out  1   memory read request
//  MemWrData  out  W   memory write data (= RfRdData, combinational)
//  MemReady   in   1   memory accepts the request this cycle (Wr/RdEn && MemReady)
//  MemRdData  in   W   read data, valid the cycle after an accepted read
// BEHAVIOUR
//  Slot map (slot: addr,half): 0:00,0  1:00,1  2:01,0  3:10,0  4:11,0  5:11,1.
//  Slot k uses MemAddr = BaseAddr + k, mod 2**MA (wraps, no error).
//  Reset (ResetN=0 at posedge): state IDLE, slot=0.
//   All outputs 0, incl. Busy, Done, RfWriteEn, MemWrEn, MemRdEn.
//  FSM states: IDLE, SAVE, RD_REQ, RD_WR, DONE.
//  IDLE: if Start, latch Mode/BaseAddr, slot=0; next is SAVE (Mode=0) or RD_REQ (Mode=1).
//  SAVE: drive RfRaddr/RfUppOrLow for slot, MemWrEn=1, MemAddr.
//   On MemReady: slot++; after slot 5 go to DONE. Without MemReady, hold all outputs.
//  RD_REQ: MemRdEn=1, MemAddr for slot; on MemReady go to RD_WR, else hold.
//  RD_WR: RfWriteEn=1, RfWaddr/RfUppOrLow for slot, RfDataIn=MemRdData.
//   Exactly 1 cycle; slot++; then RD_REQ, or DONE after slot 5.
//  DONE: Done=1, Busy=0 for one cycle, then IDLE. Start in DONE is ignored.
//  Start while Busy is ignored; latched Mode/BaseAddr are unaffected.
//  Latency, MemReady always 1, Start accepted at edge 0:
//   save writes in cycles 1-6, Done in cycle 7.
//   restore RF writes in cycles 2,4,..,12; Done in cycle 13.
//  Unused address/data outputs are 0 when the matching strobe is low.
//  RfUppOrLow is 0 for slots 2 and 3.
//  Reset mid-operation: immediate return to IDLE, no further strobes.
//   Partial memory/RF contents are left as written.
//  Never asserts RfWriteEn and MemWrEn in the same cycle.
// TESTING
//  Save, Base=0x20, RF = {11,22,33,44,55,66}, MemReady=1
//   -> mem[0x20..0x25] = 11..66; Done at cycle 7.
//  Restore, Base=0x20 holding AA..FF
//   -> 6 RF writes with (Waddr,half) per slot map, data AA..FF; Done at cycle 13.
//  Save, MemReady low cycles 2-4 -> slot 1 held 3 extra cycles; same final data; Done at cycle 10.
//  Base=0xFE save -> addresses FE,FF,00,01,02,03.
//  ResetN low at cycle 3 of a save -> outputs 0 next cycle; mem[Base+3..5] untouched; no Done.
//  Start with Mode=1 while a save is Busy -> ignored; Start in IDLE afterwards -> accepted.

Source files
------------

// File: rtl/regfile_spill.sv
// Register-file context save/restore engine: walks six RF slots and
// spills them to data memory or fills them back from it.
module regfile_spill #(
  parameter int W  = 8,
  parameter int A  = 2,
  parameter int MA = 8
) (
  input  logic          Clk,
  input  logic          ResetN,
  input  logic          Start,
  input  logic          Mode,
  input  logic [MA-1:0] BaseAddr,
  output logic          Busy,
  output logic          Done,
  output logic [A-1:0]  RfRaddr,
  output logic [A-1:0]  RfWaddr,
  output logic          RfUppOrLow,
  output logic          RfWriteEn,
  output logic [W-1:0]  RfDataIn,
  input  logic [W-1:0]  RfRdData,
  output logic [MA-1:0] MemAddr,
  output logic          MemWrEn,
  output logic          MemRdEn,
  output logic [W-1:0]  MemWrData,
  input  logic          MemReady,
  input  logic [W-1:0]  MemRdData
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_RD_REQ,
    S_RD_WR,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    slot_q, slot_d;
  logic          mode_q, mode_d;
  logic [MA-1:0] base_q, base_d;

  logic [A-1:0]  slot_addr;
  logic          slot_half;
  logic [MA-1:0] slot_maddr;
  logic          last_slot;

  always_comb begin
    slot_addr = '0;
    slot_half = 1'b0;
    unique case (slot_q)
      3'd0: begin slot_addr = A'(0); slot_half = 1'b0; end
      3'd1: begin slot_addr = A'(0); slot_half = 1'b1; end
      3'd2: begin slot_addr = A'(1); slot_half = 1'b0; end
      3'd3: begin slot_addr = A'(2); slot_half = 1'b0; end
      3'd4: begin slot_addr = A'(3); slot_half = 1'b0; end
      3'd5: begin slot_addr = A'(3); slot_half = 1'b1; end
      default: ;
    endcase
  end

  assign slot_maddr = base_q + MA'(slot_q);
  assign last_slot  = (slot_q == 3'd5);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    mode_d  = mode_q;
    base_d  = base_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          mode_d  = Mode;
          base_d  = BaseAddr;
          slot_d  = '0;
          state_d = Mode ? S_RD_REQ : S_SAVE;
        end
      end
      S_SAVE: begin
        if (MemReady) begin
          if (last_slot) begin
            slot_d  = '0;
            state_d = S_DONE;
          end else begin
            slot_d = slot_q + 3'd1;
          end
        end
      end
      S_RD_REQ: begin
        if (MemReady) state_d = S_RD_WR;
      end
      S_RD_WR: begin
        if (last_slot) begin
          slot_d  = '0;
          state_d = S_DONE;
        end else begin
          slot_d  = slot_q + 3'd1;
          state_d = S_RD_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      mode_q  <= 1'b0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
    end
  end

  // Outputs decode straight from registered state; idle buses read as zero.
  always_comb begin
    Busy       = 1'b0;
    Done       = 1'b0;
    RfRaddr    = '0;
    RfWaddr    = '0;
    RfUppOrLow = 1'b0;
    RfWriteEn  = 1'b0;
    RfDataIn   = '0;
    MemAddr    = '0;
    MemWrEn    = 1'b0;
    MemRdEn    = 1'b0;
    MemWrData  = '0;
    unique case (state_q)
      S_SAVE: begin
        Busy       = 1'b1;
        RfRaddr    = slot_addr;
        RfUppOrLow = slot_half;
        MemAddr    = slot_maddr;
        MemWrEn    = 1'b1;
        MemWrData  = RfRdData;
      end
      S_RD_REQ: begin
        Busy    = 1'b1;
        MemAddr = slot_maddr;
        MemRdEn = 1'b1;
      end
      S_RD_WR: begin
        Busy       = 1'b1;
        RfWaddr    = slot_addr;
        RfUppOrLow = slot_half;
        RfWriteEn  = 1'b1;
        RfDataIn   = MemRdData;
      end
      S_DONE:  Done = 1'b1;
      default: ;
    endcase
  end

endmodule
